base_unpacker: RTL and testbench

Upstream stage of the 2-bit-to-ASCII decode path. It accepts packed genome words carrying up to BASES 2-bit nucleotide codes (A=00, C=01, T=10, G=11) over a valid/ready handshake. It serialises them at one base per cycle onto a registered valid/ready output that drives the 2-bit input of the ASCII expander. It also tracks end-of-sequence, reports zero-count input words, and counts bases emitted.

---
 rtl/base_unpacker_if.sv | 28 ++
 rtl/base_unpacker.sv | 109 ++++++++++
 tb/tb_base_unpacker.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/base_unpacker_if.sv
// Valid/ready bundle for base_unpacker: packed-word input side and 2-bit base output side.
// The slave modport is the unpacker; the master modport is its upstream/downstream partner.
interface base_unpacker_if #(
    parameter int BASES = 16
);
    localparam int WORD_W = 2 * BASES;
    localparam int CNT_W  = $clog2(BASES) + 1;

    logic [WORD_W-1:0] in_data;
    logic [CNT_W-1:0]  in_count;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        out_base;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_count, in_last, in_valid, out_ready,
        output in_ready, out_base, out_last, out_valid
    );

    modport master (
        output in_data, in_count, in_last, in_valid, out_ready,
        input  in_ready, out_base, out_last, out_valid
    );
endinterface

// File: rtl/base_unpacker.sv
// Serialises packed 2-bit nucleotide words into one base per cycle for the ASCII expander.
// Optional UNPACK_MSB_FIRST_EN: take base 0 from the top of the word and shift left.
module base_unpacker #(
    parameter int BASES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    base_unpacker_if.slave  bus,
    output logic            err_zero_o,
    output logic [31:0]     base_total_o
);
    localparam int WORD_W = 2 * BASES;
    localparam int CNT_W  = $clog2(BASES) + 1;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] EMIT  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              last_q, last_d;
    logic              out_last_q, out_last_d;
    logic              err_zero_q, err_zero_d;
    logic [31:0]       total_q, total_d;

    logic              in_fire;
    logic              out_fire;
    logic              rem_one;
    logic [CNT_W-1:0]  cnt_clamp;
    logic [WORD_W-1:0] sr_shift;
    logic [1:0]        head_base;

`ifdef UNPACK_MSB_FIRST_EN
    assign head_base = sr_q[WORD_W-1 -: 2];
    assign sr_shift  = {sr_q[WORD_W-3:0], 2'b00};
`else
    assign head_base = sr_q[1:0];
    assign sr_shift  = {2'b00, sr_q[WORD_W-1:2]};
`endif

    assign rem_one   = (rem_q == CNT_W'(1));
    assign out_fire  = (state_q == EMIT) && bus.out_ready;
    // The last base of a word frees the slot in the same cycle, so words stream with no bubble.
    assign bus.in_ready = (state_q == EMPTY) || (out_fire && rem_one);
    assign in_fire   = bus.in_valid && bus.in_ready;
    assign cnt_clamp = (bus.in_count > CNT_W'(BASES)) ? CNT_W'(BASES) : bus.in_count;

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        sr_d       = sr_q;
        rem_d      = rem_q;
        last_d     = last_q;
        err_zero_d = err_zero_q;
        total_d    = total_q;

        if (out_fire) begin
            total_d = total_q + 32'd1;
            if (rem_one) begin
                state_d = EMPTY;
                rem_d   = '0;
            end else begin
                sr_d  = sr_shift;
                rem_d = rem_q - CNT_W'(1);
            end
        end

        if (in_fire) begin
            if (bus.in_count == '0) begin
                // Zero-count words are dropped entirely, In_Last included.
                err_zero_d = 1'b1;
            end else begin
                state_d = EMIT;
                sr_d    = bus.in_data;
                rem_d   = cnt_clamp;
                last_d  = bus.in_last;
            end
        end

        out_last_d = last_d && (rem_d == CNT_W'(1)) && (state_d == EMIT);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            sr_q       <= '0;
            rem_q      <= '0;
            last_q     <= 1'b0;
            out_last_q <= 1'b0;
            err_zero_q <= 1'b0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            rem_q      <= rem_d;
            last_q     <= last_d;
            out_last_q <= out_last_d;
            err_zero_q <= err_zero_d;
            total_q    <= total_d;
        end
    end

    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_base  = head_base;
    assign bus.out_last  = out_last_q;
    assign err_zero_o    = err_zero_q;
    assign base_total_o  = total_q;
endmodule

// File: tb/tb_base_unpacker.sv
// Directed bench for base_unpacker: a reference model fills a scoreboard of expected bases,
// and a negedge monitor pops and compares every base the DUT hands downstream.
module tb_base_unpacker;
    localparam int BASES  = 16;
    localparam int WORD_W = 2 * BASES;
    localparam int CNT_W  = $clog2(BASES) + 1;

    typedef struct packed {
        logic [1:0] base;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_zero;
    logic [31:0] base_total;

    base_unpacker_if #(.BASES(BASES)) bus ();

    base_unpacker #(.BASES(BASES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .err_zero_o   (err_zero),
        .base_total_o (base_total)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   exp_total = 0;
    int   fires = 0;
    int   run_len = 0;
    int   max_run = 0;
    logic stalled = 1'b0;
    logic [1:0] held_base = 2'b00;
    logic held_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Negedge monitor: scoreboard compare, running total, hold rule and valid-run length.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
            stalled = 1'b0;
        end else begin
            check("base_total", base_total, exp_total);
            if (stalled) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_base", 32'(bus.out_base), 32'(held_base));
                check("hold_last", 32'(bus.out_last), 32'(held_last));
            end
            if (bus.out_valid) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL sb_underflow observed=unexpected_base expected=none");
                end
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_base", 32'(bus.out_base), 32'(e.base));
                    check("out_last", 32'(bus.out_last), 32'(e.last));
                end
                exp_total++;
                fires++;
            end
            stalled   = bus.out_valid && !bus.out_ready;
            held_base = bus.out_base;
            held_last = bus.out_last;
        end
    end

    // Drive a word at a negedge, queue its expected bases, wait for acceptance, return at the next negedge.
    task automatic send(input logic [WORD_W-1:0] data, input logic [CNT_W-1:0] count, input logic last);
        int   c;
        int   t;
        exp_t e;
        c = (int'(count) > BASES) ? BASES : int'(count);
        for (int k = 0; k < c; k++) begin
`ifdef UNPACK_MSB_FIRST_EN
            e.base = data[WORD_W-1-2*k -: 2];
`else
            e.base = data[2*k +: 2];
`endif
            e.last = last && (k == c - 1);
            exp_q.push_back(e);
        end
        bus.in_data  = data;
        bus.in_count = count;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        for (t = 0; t < 200 && !bus.in_ready; t++) @(negedge clk);
        check("accept_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300; t++) begin
            if (exp_q.size() == 0 && !bus.out_valid) break;
            @(negedge clk);
        end
        check("drain", 32'(exp_q.size()) | 32'(bus.out_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int f0;
        bus.in_data   = '0;
        bus.in_count  = '0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset values.
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_base", 32'(bus.out_base), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_err_zero", 32'(err_zero), 32'd0);
        check("rst_total", base_total, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Full 16-base word, free-flowing output.
        send(32'h0000_001B, CNT_W'(16), 1'b1);
        check("first_valid", 32'(bus.out_valid), 32'd1);
        wait_drain();
        check("total_after_16", base_total, 32'd16);

        // Back-to-back words of 2 then 3 bases.
        max_run = 0;
        send(32'h0000_0006, CNT_W'(2), 1'b0);
        check("b2b_ready_low", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        check("b2b_ready_last", 32'(bus.in_ready), 32'd1);
        check("b2b_valid_last", 32'(bus.out_valid), 32'd1);
        send(32'h0000_0027, CNT_W'(3), 1'b1);
        wait_drain();
        check("b2b_run", 32'(max_run), 32'd5);

        // Backpressure: 4 stalled cycles in the middle of an 8-base word.
        max_run = 0;
        send(32'h0000_E4B1, CNT_W'(8), 1'b1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b1;
        wait_drain();
        check("stall_run", 32'(max_run), 32'd12);

        // Zero-count word is dropped with its In_Last, then a 5-base word.
        f0 = fires;
        send(32'hFFFF_FFFF, CNT_W'(0), 1'b1);
        check("zero_err", 32'(err_zero), 32'd1);
        check("zero_idle", 32'(bus.out_valid), 32'd0);
        send(32'h0000_02D8, CNT_W'(5), 1'b0);
        wait_drain();
        check("zero_count5", 32'(fires - f0), 32'd5);
        check("zero_err_sticky", 32'(err_zero), 32'd1);

        // Count above BASES is clamped.
        f0 = fires;
        send(32'h9C3F_5A01, CNT_W'(20), 1'b1);
        wait_drain();
        check("clamp_count", 32'(fires - f0), 32'd16);

        // Reset after 3 of 16 bases.
        f0 = fires;
        send(32'hA5A5_1234, CNT_W'(16), 1'b1);
        for (int t = 0; t < 100 && fires < f0 + 3; t++) @(posedge clk);
        check("pre_reset_fires", 32'(fires - f0), 32'd3);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_total = 0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_total", base_total, 32'd0);
        check("mid_rst_err", 32'(err_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        f0 = fires;
        send(32'h0000_0E4E, CNT_W'(6), 1'b1);
        wait_drain();
        check("post_rst_count", 32'(fires - f0), 32'd6);
        check("post_rst_total", base_total, 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
